instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Parametrised fetch stage for the MIPS pipeline. It owns the PC, the instruction memory and a byte-serial program loader. Compared with the previous fetch stage it adds:
- configurable data, byte and address widths;
- an explicit LOAD/RUN/HALTED state machine;
- a debug single-step mode;
- a program-bound end check;
- a configurable halt opcode.

It sits between the debug/UART loader and the IF/ID pipeline register.

Parameters:
NB_DATA, 32, instruction and PC width; must be a multiple of NB_BYTE
NB_BYTE, 8, loader byte width
NB_INSTRUCTION_ADDRESS, 7, byte-address bits of instruction memory; depth = 2^NB_INSTRUCTION_ADDRESS / (NB_DATA/NB_BYTE) words
HALT_OPCODE, 32'hFFFF_FFFF, instruction word that ends the program

Ports:
i_clock  in  1  clock, all state updates on its rising edge
i_reset  in  1  asynchronous, active-high reset
i_load_start  in  1  pulse: enter LOAD and clear the write pointer
i_load_byte  in  NB_BYTE  program byte, big-endian (first byte becomes the MSB)
i_load_valid  in  1  qualifies i_load_byte
i_load_done  in  1  pulse: leave LOAD and enter RUN with PC=0
i_pc_reset  in  1  PC to 0; from HALTED, return to RUN; program is kept
i_stall  in  1  1 = hold the PC
i_is_jump_or_branch  in  1  redirect the PC
i_next_pc  in  NB_DATA  redirect target
i_step_mode  in  1  1 = PC advances only on i_step
i_step  in  1  single-step pulse
o_instruction  out  NB_DATA  instruction at the PC (combinational read)
o_pc_value  out  NB_DATA  current PC
o_pc_plus4  out  NB_DATA  PC + bytes-per-word
o_valid  out  1  o_instruction is valid (state RUN)
o_is_end  out  1  halt reached or PC beyond the loaded program
o_load_overflow  out  1  sticky: a byte arrived after memory was full
o_words_loaded  out  NB_INSTRUCTION_ADDRESS  count of complete words written

Behaviour:
Reset (asynchronous, active-high):
- state=LOAD; PC=0; byte counter=0; write pointer=0; assembly register=0.
- All outputs 0, except o_pc_plus4 = bytes-per-word.
- Memory contents are not cleared.

State LOAD:
- Each i_load_valid shifts i_load_byte into the assembly register.
- On the (NB_DATA/NB_BYTE)-th byte the full word is written at the write pointer on that clock edge; the pointer increments and the byte counter returns to 0.
- When the pointer equals depth, further bytes are dropped and o_load_overflow is set; it stays set until reset or i_load_start.
- i_load_done moves to RUN with PC=0.
- A partial word pending at i_load_done is discarded.
- o_valid=0.

State RUN:
- o_valid=1; instruction = mem[PC word index]; zero-latency read.
- Next-PC priority, highest first:
  1. i_load_start: go to LOAD, write pointer=0, overflow cleared.
  2. i_pc_reset: PC=0.
  3. i_stall: hold.
  4. Step mode with i_step=0: hold.
  5. i_is_jump_or_branch: PC = i_next_pc with its low log2(bytes-per-word) bits forced to 0.
  6. o_instruction == HALT_OPCODE: go to HALTED, PC held.
  7. Otherwise PC = PC + bytes-per-word.
- Redirect beats halt detection.
- A PC word index ≥ o_words_loaded asserts o_is_end combinationally and freezes the PC, as for a halt. No memory read beyond the program is exposed: o_instruction is forced to 0.
- PC arithmetic is modulo 2^NB_DATA. The memory index uses only the PC address bits, so it wraps; the bound check still applies.

State HALTED:
- o_is_end=1; o_valid=0; PC held.
- i_pc_reset goes to RUN with PC=0.
- i_load_start goes to LOAD.
- All other inputs are ignored.

Asynchronous reset mid-load abandons the partial word; words already written remain.

Decomposition:
Shared package mips_fetch_pkg holds:
- the state encoding (FETCH_LOAD, FETCH_RUN, FETCH_HALTED);
- BYTES_PER_WORD;
- the HALT_OPCODE default.

One sub-module: instruction_word_ram, with a synchronous word write and a combinational read. Its parameters are depth and NB_DATA. The loader FSM, PC logic and bound check stay in the top module.

Test Plan:
1. Load bytes 20,08,00,05 / 20,09,00,07 / FF,FF,FF,FF, then i_load_done -> o_words_loaded=3. RUN: PC 0 gives 0x20080005, PC 4 gives 0x20090007. At PC 8 the next cycle is HALTED, o_is_end=1, o_pc_value=8.
2. In RUN, i_stall=1 for 3 cycles at PC=4 -> PC holds at 4. The cycle after release -> PC=8.
3. i_is_jump_or_branch=1 with i_next_pc=0x0000_0006 while the halt word is at PC -> PC=4 and no halt. Same cycle with i_stall=1 -> stall wins, PC unchanged.
4. Load 2 words, no halt -> after PC=4 the PC reaches 8, o_is_end=1, o_instruction=0, PC frozen. Then i_pc_reset -> RUN, PC=0.
5. Load depth+1 words -> o_load_overflow=1 and o_words_loaded=depth. i_load_start -> overflow cleared.
6. i_step_mode=1 with three i_step pulses spaced 4 cycles apart -> PC = 0, 4, 8, 12 only after each pulse. Assert i_reset mid-load after 2 bytes -> all outputs return to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_fetch_pkg
// Description : Shared definitions for the MIPS fetch stage: the fetch state
//               encoding, the default bytes-per-word and the default halt
//               opcode.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_LOAD   = 2'd0,
        FETCH_RUN    = 2'd1,
        FETCH_HALTED = 2'd2
    } fetch_state_t;

    // Default geometry: 32-bit words assembled from 8-bit loader bytes.
    localparam int          BYTES_PER_WORD      = 4;
    localparam logic [31:0] HALT_OPCODE_DEFAULT = 32'hFFFF_FFFF;

endpackage : mips_fetch_pkg
`default_nettype wire

// File: rtl/instruction_word_ram.sv
`default_nettype none
// ============================================================================
// Module      : instruction_word_ram
// Description : Word-wide instruction memory, synchronous write and
//               combinational (zero-latency) read. Contents are not reset.
// Ports       : i_clock    - write clock
//               i_wr_en    - write strobe
//               i_wr_addr  - word write address
//               i_wr_data  - word to write
//               i_rd_addr  - word read address
//               o_rd_data  - word at i_rd_addr
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_word_ram #(
    parameter int DEPTH   = 32,
    parameter int NB_DATA = 32
) (
    input  logic                     i_clock,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [NB_DATA-1:0]       i_wr_data,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [NB_DATA-1:0]       o_rd_data
);

    logic [NB_DATA-1:0] mem_q [DEPTH];

    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem_q[i_rd_addr];

endmodule : instruction_word_ram
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : MIPS fetch stage. Owns the PC, the instruction memory and a
//               byte-serial big-endian program loader. LOAD/RUN/HALTED state
//               machine, debug single-step, program-bound end check and a
//               configurable halt opcode.
// Ports       : i_clock/i_reset            - clock, async active-high reset
//               i_load_start/_byte/_valid/_done - program loader
//               i_pc_reset, i_stall, i_is_jump_or_branch, i_next_pc,
//               i_step_mode, i_step         - PC control
//               o_instruction, o_pc_value, o_pc_plus4, o_valid, o_is_end,
//               o_load_overflow, o_words_loaded - fetch/loader status
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int                   NB_DATA                = 32,
    parameter int                   NB_BYTE                = 8,
    parameter int                   NB_INSTRUCTION_ADDRESS = 7,
    parameter logic [NB_DATA-1:0]   HALT_OPCODE            = HALT_OPCODE_DEFAULT
) (
    input  logic                              i_clock,
    input  logic                              i_reset,
    input  logic                              i_load_start,
    input  logic [NB_BYTE-1:0]                i_load_byte,
    input  logic                              i_load_valid,
    input  logic                              i_load_done,
    input  logic                              i_pc_reset,
    input  logic                              i_stall,
    input  logic                              i_is_jump_or_branch,
    input  logic [NB_DATA-1:0]                i_next_pc,
    input  logic                              i_step_mode,
    input  logic                              i_step,
    output logic [NB_DATA-1:0]                o_instruction,
    output logic [NB_DATA-1:0]                o_pc_value,
    output logic [NB_DATA-1:0]                o_pc_plus4,
    output logic                              o_valid,
    output logic                              o_is_end,
    output logic                              o_load_overflow,
    output logic [NB_INSTRUCTION_ADDRESS-1:0] o_words_loaded
);

    localparam int c_WORD_BYTES = NB_DATA / NB_BYTE;
    localparam int c_OFS_W      = $clog2(c_WORD_BYTES);
    localparam int c_DEPTH      = (2 ** NB_INSTRUCTION_ADDRESS) / c_WORD_BYTES;
    localparam int c_IDX_W      = NB_INSTRUCTION_ADDRESS - c_OFS_W;
    // One extra bit so the pointer can hold the value DEPTH (memory full).
    localparam int c_PTR_W      = c_IDX_W + 1;
    localparam int c_CNT_W      = (c_OFS_W > 0) ? c_OFS_W : 1;

    fetch_state_t         state_q, state_d;
    logic [NB_DATA-1:0]   pc_q, pc_d;
    logic [NB_DATA-1:0]   asm_q, asm_d;
    logic [c_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic                 overflow_q, overflow_d;

    logic                 w_wr_en;
    logic [NB_DATA-1:0]   w_asm_shift;
    logic [NB_DATA-1:0]   w_rd_data;
    logic [NB_DATA-1:0]   w_pc_plus;
    logic [NB_DATA-1:0]   w_pc_word;
    logic                 w_in_bound;
    logic                 w_mem_full;
    logic [NB_DATA-1:0]   w_instruction;

    assign w_asm_shift = (asm_q << NB_BYTE) | NB_DATA'(i_load_byte);
    assign w_pc_plus   = pc_q + NB_DATA'(c_WORD_BYTES);
    // Bound check uses the full PC, so a PC that wraps the memory index
    // is still flagged as beyond the program.
    assign w_pc_word   = pc_q >> c_OFS_W;
    assign w_in_bound  = (w_pc_word < NB_DATA'(wr_ptr_q));
    assign w_mem_full  = (wr_ptr_q == c_PTR_W'(c_DEPTH));

    instruction_word_ram #(
        .DEPTH   (c_DEPTH),
        .NB_DATA (NB_DATA)
    ) u_ram (
        .i_clock   (i_clock),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (wr_ptr_q[c_IDX_W-1:0]),
        .i_wr_data (w_asm_shift),
        .i_rd_addr (pc_q[NB_INSTRUCTION_ADDRESS-1:c_OFS_W]),
        .o_rd_data (w_rd_data)
    );

    // Nothing beyond the loaded program is ever exposed.
    assign w_instruction = (state_q == FETCH_RUN && w_in_bound) ? w_rd_data : '0;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        asm_d      = asm_q;
        wr_ptr_d   = wr_ptr_q;
        byte_cnt_d = byte_cnt_q;
        overflow_d = overflow_q;
        w_wr_en    = 1'b0;

        if (i_load_start) begin
            state_d    = FETCH_LOAD;
            pc_d       = '0;
            asm_d      = '0;
            wr_ptr_d   = '0;
            byte_cnt_d = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                FETCH_LOAD: begin
                    if (i_load_done) begin
                        // Any partial word still being assembled is dropped.
                        state_d    = FETCH_RUN;
                        pc_d       = '0;
                        byte_cnt_d = '0;
                    end else if (i_load_valid) begin
                        if (w_mem_full) begin
                            overflow_d = 1'b1;
                        end else begin
                            asm_d = w_asm_shift;
                            if (byte_cnt_q == c_CNT_W'(c_WORD_BYTES - 1)) begin
                                w_wr_en    = 1'b1;
                                wr_ptr_d   = wr_ptr_q + c_PTR_W'(1);
                                byte_cnt_d = '0;
                            end else begin
                                byte_cnt_d = byte_cnt_q + c_CNT_W'(1);
                            end
                        end
                    end
                end
                FETCH_RUN: begin
                    if (i_pc_reset) begin
                        pc_d = '0;
                    end else if (i_stall || (i_step_mode && !i_step)) begin
                        pc_d = pc_q;
                    end else if (i_is_jump_or_branch) begin
                        pc_d = i_next_pc & ~NB_DATA'(c_WORD_BYTES - 1);
                    end else if (!w_in_bound) begin
                        pc_d = pc_q;
                    end else if (w_instruction == HALT_OPCODE) begin
                        state_d = FETCH_HALTED;
                    end else begin
                        pc_d = w_pc_plus;
                    end
                end
                FETCH_HALTED: begin
                    if (i_pc_reset) begin
                        state_d = FETCH_RUN;
                        pc_d    = '0;
                    end
                end
                default: begin
                    state_d = FETCH_LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= FETCH_LOAD;
            pc_q       <= '0;
            asm_q      <= '0;
            wr_ptr_q   <= '0;
            byte_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            asm_q      <= asm_d;
            wr_ptr_q   <= wr_ptr_d;
            byte_cnt_q <= byte_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_instruction   = w_instruction;
    assign o_pc_value      = pc_q;
    assign o_pc_plus4      = w_pc_plus;
    assign o_valid         = (state_q == FETCH_RUN);
    assign o_is_end        = (state_q == FETCH_HALTED) ||
                             (state_q == FETCH_RUN && !w_in_bound);
    assign o_load_overflow = overflow_q;
    assign o_words_loaded  = NB_INSTRUCTION_ADDRESS'(wr_ptr_q);

endmodule : instruction_fetch_unit
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Directed self-checking bench for instruction_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_load_start = 1'b0;
    logic [7:0]  i_load_byte = 8'h00;
    logic        i_load_valid = 1'b0;
    logic        i_load_done = 1'b0;
    logic        i_pc_reset = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_is_jump_or_branch = 1'b0;
    logic [31:0] i_next_pc = 32'h0;
    logic        i_step_mode = 1'b0;
    logic        i_step = 1'b0;
    logic [31:0] o_instruction, o_pc_value, o_pc_plus4;
    logic        o_valid, o_is_end, o_load_overflow;
    logic [6:0]  o_words_loaded;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .i_clock             (clk),
        .i_reset             (i_reset),
        .i_load_start        (i_load_start),
        .i_load_byte         (i_load_byte),
        .i_load_valid        (i_load_valid),
        .i_load_done         (i_load_done),
        .i_pc_reset          (i_pc_reset),
        .i_stall             (i_stall),
        .i_is_jump_or_branch (i_is_jump_or_branch),
        .i_next_pc           (i_next_pc),
        .i_step_mode         (i_step_mode),
        .i_step              (i_step),
        .o_instruction       (o_instruction),
        .o_pc_value          (o_pc_value),
        .o_pc_plus4          (o_pc_plus4),
        .o_valid             (o_valid),
        .o_is_end            (o_is_end),
        .o_load_overflow     (o_load_overflow),
        .o_words_loaded      (o_words_loaded)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_load();
        i_load_start = 1'b1; tick(); i_load_start = 1'b0;
    endtask

    task automatic finish_load();
        i_load_done = 1'b1; tick(); i_load_done = 1'b0;
    endtask

    task automatic load_byte(input logic [7:0] b);
        i_load_byte = b; i_load_valid = 1'b1; tick(); i_load_valid = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] w);
        load_byte(w[31:24]); load_byte(w[23:16]); load_byte(w[15:8]); load_byte(w[7:0]);
    endtask

    task automatic test_reset();
        tick(); tick();
        i_reset = 1'b0;
        tick();
        vectors++; if (o_pc_value !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h need %h", o_pc_value, 32'h0); end
        vectors++; if (o_pc_plus4 !== 32'h4) begin miscompares++; $display("FAIL reset_pc_plus4 got %h need %h", o_pc_plus4, 32'h4); end
        vectors++; if ({o_valid, o_is_end, o_load_overflow} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %b need 000", {o_valid, o_is_end, o_load_overflow}); end
        vectors++; if (o_words_loaded !== 7'd0) begin miscompares++; $display("FAIL reset_words got %0d need 0", o_words_loaded); end
        vectors++; if (o_instruction !== 32'h0) begin miscompares++; $display("FAIL reset_instr got %h need 0", o_instruction); end
    endtask

    task automatic test_program_halt();
        begin_load();
        load_word(32'h2008_0005); load_word(32'h2009_0007); load_word(32'hFFFF_FFFF);
        vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("FAIL load_valid got %b need 0", o_valid); end
        finish_load();
        vectors++; if (o_words_loaded !== 7'd3) begin miscompares++; $display("FAIL words3 got %0d need 3", o_words_loaded); end
        vectors++; if (o_instruction !== 32'h2008_0005 || o_pc_value !== 32'h0 || o_valid !== 1'b1) begin miscompares++; $display("FAIL pc0 got pc=%h instr=%h v=%b need pc=0 instr=20080005 v=1", o_pc_value, o_instruction, o_valid); end
        tick();
        vectors++; if (o_instruction !== 32'h2009_0007 || o_pc_value !== 32'h4) begin miscompares++; $display("FAIL pc4 got pc=%h instr=%h need pc=4 instr=20090007", o_pc_value, o_instruction); end
        vectors++; if (o_pc_plus4 !== 32'h8) begin miscompares++; $display("FAIL pc_plus4 got %h need 8", o_pc_plus4); end
        tick();
        vectors++; if (o_pc_value !== 32'h8 || o_instruction !== 32'hFFFF_FFFF || o_is_end !== 1'b0) begin miscompares++; $display("FAIL pc8_run got pc=%h instr=%h end=%b need pc=8 instr=ffffffff end=0", o_pc_value, o_instruction, o_is_end); end
        tick();
        vectors++; if (o_pc_value !== 32'h8 || o_is_end !== 1'b1 || o_valid !== 1'b0) begin miscompares++; $display("FAIL halted got pc=%h end=%b v=%b need pc=8 end=1 v=0", o_pc_value, o_is_end, o_valid); end
        i_stall = 1'b0; i_is_jump_or_branch = 1'b1; i_next_pc = 32'h0; tick(); i_is_jump_or_branch = 1'b0;
        vectors++; if (o_pc_value !== 32'h8 || o_is_end !== 1'b1) begin miscompares++; $display("FAIL halted_ignore got pc=%h end=%b need pc=8 end=1", o_pc_value, o_is_end); end
    endtask

    task automatic test_stall();
        i_pc_reset = 1'b1; tick(); i_pc_reset = 1'b0;
        vectors++; if (o_pc_value !== 32'h0 || o_valid !== 1'b1 || o_is_end !== 1'b0) begin miscompares++; $display("FAIL pc_reset_run got pc=%h v=%b end=%b need pc=0 v=1 end=0", o_pc_value, o_valid, o_is_end); end
        tick();
        i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++; if (o_pc_value !== 32'h4) begin miscompares++; $display("FAIL stall_hold%0d got %h need 4", k, o_pc_value); end
        end
        i_stall = 1'b0; tick();
        vectors++; if (o_pc_value !== 32'h8) begin miscompares++; $display("FAIL stall_release got %h need 8", o_pc_value); end
    endtask

    task automatic test_redirect();
        i_is_jump_or_branch = 1'b1; i_next_pc = 32'h0000_0006; i_stall = 1'b1; tick();
        vectors++; if (o_pc_value !== 32'h8 || o_valid !== 1'b1) begin miscompares++; $display("FAIL stall_over_jump got pc=%h v=%b need pc=8 v=1", o_pc_value, o_valid); end
        i_stall = 1'b0; tick(); i_is_jump_or_branch = 1'b0;
        vectors++; if (o_pc_value !== 32'h4 || o_valid !== 1'b1 || o_is_end !== 1'b0) begin miscompares++; $display("FAIL jump_over_halt got pc=%h v=%b end=%b need pc=4 v=1 end=0", o_pc_value, o_valid, o_is_end); end
    endtask

    task automatic test_bound();
        begin_load();
        vectors++; if (o_valid !== 1'b0 || o_words_loaded !== 7'd0) begin miscompares++; $display("FAIL run_to_load got v=%b words=%0d need v=0 words=0", o_valid, o_words_loaded); end
        load_word(32'h1111_1111); load_word(32'h2222_2222);
        finish_load();
        vectors++; if (o_words_loaded !== 7'd2 || o_instruction !== 32'h1111_1111) begin miscompares++; $display("FAIL bound_start got words=%0d instr=%h need 2/11111111", o_words_loaded, o_instruction); end
        tick(); tick();
        vectors++; if (o_pc_value !== 32'h8 || o_is_end !== 1'b1 || o_instruction !== 32'h0) begin miscompares++; $display("FAIL bound_end got pc=%h end=%b instr=%h need pc=8 end=1 instr=0", o_pc_value, o_is_end, o_instruction); end
        tick();
        vectors++; if (o_pc_value !== 32'h8) begin miscompares++; $display("FAIL bound_freeze got %h need 8", o_pc_value); end
        i_pc_reset = 1'b1; tick(); i_pc_reset = 1'b0;
        vectors++; if (o_pc_value !== 32'h0 || o_is_end !== 1'b0 || o_valid !== 1'b1) begin miscompares++; $display("FAIL bound_pc_reset got pc=%h end=%b v=%b need 0/0/1", o_pc_value, o_is_end, o_valid); end
    endtask

    task automatic test_overflow();
        begin_load();
        for (int n = 0; n < 32; n++) load_word(32'h1000_0000 + n);
        vectors++; if (o_words_loaded !== 7'd32 || o_load_overflow !== 1'b0) begin miscompares++; $display("FAIL full_no_ovf got words=%0d ovf=%b need 32/0", o_words_loaded, o_load_overflow); end
        load_word(32'hDEAD_BEEF);
        vectors++; if (o_words_loaded !== 7'd32 || o_load_overflow !== 1'b1) begin miscompares++; $display("FAIL overflow got words=%0d ovf=%b need 32/1", o_words_loaded, o_load_overflow); end
        begin_load();
        vectors++; if (o_load_overflow !== 1'b0 || o_words_loaded !== 7'd0) begin miscompares++; $display("FAIL ovf_clear got ovf=%b words=%0d need 0/0", o_load_overflow, o_words_loaded); end
    endtask

    task automatic test_step();
        load_word(32'hA000_0000); load_word(32'hA000_0001);
        load_word(32'hA000_0002); load_word(32'hA000_0003);
        i_step_mode = 1'b1;
        finish_load();
        for (int k = 1; k <= 3; k++) begin
            tick(); tick(); tick();
            vectors++; if (o_pc_value !== 32'(4 * (k - 1))) begin miscompares++; $display("FAIL step_hold%0d got %h need %h", k, o_pc_value, 32'(4 * (k - 1))); end
            i_step = 1'b1; tick(); i_step = 1'b0;
            vectors++; if (o_pc_value !== 32'(4 * k)) begin miscompares++; $display("FAIL step_pulse%0d got %h need %h", k, o_pc_value, 32'(4 * k)); end
        end
        vectors++; if (o_instruction !== 32'hA000_0003) begin miscompares++; $display("FAIL step_instr got %h need a0000003", o_instruction); end
        i_step_mode = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        begin_load();
        load_word(32'h1234_5678);
        load_byte(8'hAB); load_byte(8'hCD);
        vectors++; if (o_words_loaded !== 7'd1) begin miscompares++; $display("FAIL pre_reset_words got %0d need 1", o_words_loaded); end
        #2 i_reset = 1'b1;
        #1;
        vectors++; if (o_words_loaded !== 7'd0 || o_pc_value !== 32'h0 || o_pc_plus4 !== 32'h4) begin miscompares++; $display("FAIL async_reset got words=%0d pc=%h p4=%h need 0/0/4", o_words_loaded, o_pc_value, o_pc_plus4); end
        vectors++; if ({o_valid, o_is_end, o_load_overflow} !== 3'b000 || o_instruction !== 32'h0) begin miscompares++; $display("FAIL async_reset_flags got %b instr=%h need 000/0", {o_valid, o_is_end, o_load_overflow}, o_instruction); end
        #1 i_reset = 1'b0;
        tick();
        finish_load();
        vectors++; if (o_valid !== 1'b1 || o_is_end !== 1'b1 || o_instruction !== 32'h0) begin miscompares++; $display("FAIL empty_program got v=%b end=%b instr=%h need 1/1/0", o_valid, o_is_end, o_instruction); end
    endtask

    initial begin
        test_reset();
        test_program_halt();
        test_stall();
        test_redirect();
        test_bound();
        test_overflow();
        test_step();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_instruction_fetch_unit
`default_nettype wire
